// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron layer: Q8.8 weight type,
// controller state encoding and the signed 16-bit saturation function.
package perceptron_pkg;

  localparam int FRAC_BITS = 8;
  localparam int SAT_W     = 48;

  typedef logic signed [15:0] weight_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_RES,
    S_ERR,
    S_BWD,
    S_FBK
  } state_t;

  function automatic weight_t sat16(input logic signed [SAT_W-1:0] v);
    if (v > SAT_W'(32767)) return weight_t'(16'h7fff);
    if (v < SAT_W'(-32768)) return weight_t'(16'h8000);
    return v[15:0];
  endfunction

endpackage

// File: rtl/perceptron_neuron.sv
// One neuron: N Q8.8 weights plus bias, forward MAC accumulator, activation
// and the per-index weight / one-shot bias update used during training.
module perceptron_neuron
  import perceptron_pkg::*;
#(
  parameter int N        = 2,
  parameter int W        = 8,
  parameter int LR_SHIFT = 0,
  parameter int ACT      = 0,
  parameter int IDX_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_clr,
  input  logic             acc_en,
  input  logic             upd_en,
  input  logic             bias_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [W-1:0]     x_i,
  input  weight_t          e,
  output weight_t          w_i,
  output logic [W-1:0]     res
);

  localparam int ACC_W = 16 + W + $clog2(N) + 2;
  localparam logic signed [SAT_W-1:0] LIN_MAX = {{(SAT_W-W){1'b0}}, {W{1'b1}}};

  weight_t                  w_q [N];
  weight_t                  w_d [N];
  weight_t                  b_q, b_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sh;
  logic signed [W:0]        x_s;
  logic signed [16+W:0]     wx, ex, ex_sh;
  logic signed [SAT_W-1:0]  s_ext;
  weight_t                  s, dw, e_sh;

  always_comb begin
    x_s    = {1'b0, x_i};
    w_i    = w_q[idx];
    wx     = w_i * x_s;
    ex     = e * x_s;
    ex_sh  = ex >>> (W + LR_SHIFT);
    e_sh   = e >>> LR_SHIFT;
    dw     = sat16(SAT_W'(ex_sh));

    acc_d = acc_q;
    if (acc_clr) acc_d = '0;
    else if (acc_en) acc_d = acc_q + ACC_W'(wx);

    // Product sum keeps full precision; only the final Q8.8 result saturates
    acc_sh = acc_q >>> W;
    s_ext  = SAT_W'(acc_sh) + SAT_W'(b_q);
    s      = sat16(s_ext);

    res = '0;
    if (ACT == 0) begin
      if (s > 0) res = '1;
    end else begin
      if (s < 0) res = '0;
      else if (SAT_W'(s) > LIN_MAX) res = '1;
      else res = s[W-1:0];
    end

    w_d = w_q;
    if (upd_en) w_d[idx] = sat16(SAT_W'(w_i) + SAT_W'(dw));
    b_d = b_q;
    if (upd_en && bias_en) b_d = sat16(SAT_W'(b_q) + SAT_W'(e_sh));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q   <= '{default: '0};
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      w_q   <= w_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/perceptron_layer.sv
// Single-layer perceptron with on-line training: forward pass over N inputs,
// optional error intake, back-propagated error output and weight update.
module perceptron_layer
  import perceptron_pkg::*;
#(
  parameter int N        = 2,
  parameter int M        = 1,
  parameter int W        = 8,
  parameter int LR_SHIFT = 0,
  parameter int ACT      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   arg_stb,
  output logic                   arg_rdy,
  input  logic [N-1:0][W-1:0]    arg_dat,
  output logic                   res_stb,
  input  logic                   res_rdy,
  output logic [M-1:0][W-1:0]    res_dat,
  input  logic                   err_stb,
  output logic                   err_rdy,
  input  logic [M-1:0][15:0]     err_dat,
  output logic                   fbk_stb,
  input  logic                   fbk_rdy,
  output logic [N-1:0][15:0]     fbk_dat
);

  localparam int IDX_W = $clog2(N + 1);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d, i_sel;
  logic [N-1:0][W-1:0]      x_q, x_d;
  logic [M-1:0][15:0]       e_q, e_d;
  logic [M-1:0][W-1:0]      res_q, res_d, res_nrn;
  logic [N-1:0][15:0]       fbk_q, fbk_d;
  weight_t                  w_col [M];
  logic                     arg_fire, res_fire, err_fire, fbk_fire;
  logic                     acc_en, upd_en, bias_en;
  logic signed [31:0]       we_prod;
  logic signed [SAT_W-1:0]  fbk_sum;

  assign arg_rdy  = (state_q == S_IDLE);
  assign err_rdy  = (state_q == S_ERR);
  assign res_stb  = (state_q == S_RES);
  assign fbk_stb  = (state_q == S_FBK);
  assign res_dat  = res_q;
  assign fbk_dat  = fbk_q;
  assign arg_fire = arg_stb && arg_rdy;
  assign res_fire = res_stb && res_rdy;
  assign err_fire = err_stb && err_rdy;
  assign fbk_fire = fbk_stb && fbk_rdy;
  assign i_sel    = (idx_q == IDX_W'(N)) ? '0 : idx_q;
  assign acc_en   = (state_q == S_FWD) && (idx_q != IDX_W'(N));
  assign upd_en   = (state_q == S_BWD);
  assign bias_en  = (idx_q == '0);

  for (genvar j = 0; j < M; j++) begin : g_nrn
    perceptron_neuron #(
      .N(N), .W(W), .LR_SHIFT(LR_SHIFT), .ACT(ACT), .IDX_W(IDX_W)
    ) u_nrn (
      .clk(clk), .rst(rst), .acc_clr(arg_fire), .acc_en(acc_en),
      .upd_en(upd_en), .bias_en(bias_en), .idx(i_sel), .x_i(x_q[i_sel]),
      .e(weight_t'(e_q[j])), .w_i(w_col[j]), .res(res_nrn[j])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    e_d     = e_q;
    res_d   = res_q;
    fbk_d   = fbk_q;
    we_prod = '0;
    fbk_sum = '0;
    // Feedback for the current column uses the weights before this cycle's update
    for (int j = 0; j < M; j++) begin
      we_prod = w_col[j] * $signed(e_q[j]);
      fbk_sum = fbk_sum + SAT_W'(we_prod);
    end
    case (state_q)
      S_IDLE: if (arg_fire) begin
        x_d     = arg_dat;
        idx_d   = '0;
        state_d = S_FWD;
      end
      S_FWD: begin
        if (idx_q == IDX_W'(N)) begin
          res_d   = res_nrn;
          idx_d   = '0;
          state_d = S_RES;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RES: if (res_fire) state_d = en ? S_ERR : S_IDLE;
      S_ERR: if (err_fire) begin
        e_d     = err_dat;
        idx_d   = '0;
        state_d = S_BWD;
      end
      S_BWD: begin
        fbk_d[i_sel] = sat16(fbk_sum >>> FRAC_BITS);
        if (idx_q == IDX_W'(N - 1)) begin
          idx_d   = '0;
          state_d = S_FBK;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_FBK: if (fbk_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      res_q   <= '0;
      fbk_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      fbk_q   <= fbk_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
    e_q <= e_d;
  end

endmodule

// File: tb/tb_perceptron_layer.sv
// Bench for perceptron_layer: AND/OR training table, en=0 forward, stalls,
// saturation, reset mid-update and randomized traffic against a plain model.
module tb_perceptron_layer;

  localparam int N = 2, M = 2, W = 8, LR = 0, ACT = 0;

  logic clk = 1'b0;
  logic rst, en, arg_stb, arg_rdy, res_stb, res_rdy, err_stb, err_rdy, fbk_stb, fbk_rdy;
  logic [N-1:0][W-1:0] arg_dat;
  logic [M-1:0][W-1:0] res_dat;
  logic [M-1:0][15:0]  err_dat;
  logic [N-1:0][15:0]  fbk_dat;

  int n_cmp = 0, n_bad = 0;

  longint mw [M][N];
  longint mb [M];
  longint mres [M];
  longint mfbk [N];

  typedef struct {
    logic [N-1:0][W-1:0] arg;
    logic [M-1:0][W-1:0] tgt;
  } vec_t;
  vec_t tbl [4];

  perceptron_layer #(.N(N), .M(M), .W(W), .LR_SHIFT(LR), .ACT(ACT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .arg_stb(arg_stb), .arg_rdy(arg_rdy), .arg_dat(arg_dat),
    .res_stb(res_stb), .res_rdy(res_rdy), .res_dat(res_dat),
    .err_stb(err_stb), .err_rdy(err_rdy), .err_dat(err_dat),
    .fbk_stb(fbk_stb), .fbk_rdy(fbk_rdy), .fbk_dat(fbk_dat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic longint msat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic model_reset();
    for (int j = 0; j < M; j++) begin
      mb[j] = 0;
      for (int i = 0; i < N; i++) mw[j][i] = 0;
    end
  endtask

  task automatic model_fwd(input logic [N-1:0][W-1:0] x);
    longint acc, s, top;
    top = (longint'(1) << W) - 1;
    for (int j = 0; j < M; j++) begin
      acc = 0;
      for (int i = 0; i < N; i++) acc += mw[j][i] * longint'(x[i]);
      s = msat(mb[j] + (acc >>> W));
      if (ACT == 0) mres[j] = (s > 0) ? top : 0;
      else mres[j] = (s < 0) ? 0 : ((s > top) ? top : s);
    end
  endtask

  task automatic model_bwd(input logic [N-1:0][W-1:0] x, input logic [M-1:0][15:0] e);
    longint sum, ej;
    for (int i = 0; i < N; i++) begin
      sum = 0;
      for (int j = 0; j < M; j++) sum += mw[j][i] * longint'($signed(e[j]));
      mfbk[i] = msat(sum >>> 8);
    end
    for (int j = 0; j < M; j++) begin
      ej = longint'($signed(e[j]));
      for (int i = 0; i < N; i++)
        mw[j][i] = msat(mw[j][i] + msat((ej * longint'(x[i])) >>> (W + LR)));
      mb[j] = msat(mb[j] + (ej >>> LR));
    end
  endtask

  task automatic send_arg(input logic [N-1:0][W-1:0] x);
    int c = 0;
    while (!arg_rdy && c < 50) begin @(posedge clk); #1; c++; end
    if (!arg_rdy) timeout("arg_rdy");
    arg_dat = x;
    arg_stb = 1'b1;
    @(posedge clk); #1;
    arg_stb = 1'b0;
  endtask

  task automatic recv_res(input bit en_v, input int stall, input logic [M-1:0][W-1:0] exp,
                          output logic [M-1:0][W-1:0] r, output int lat);
    lat = 0;
    while (!res_stb && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!res_stb) timeout("res_stb");
    r = res_dat;
    check("res_dat", res_dat, exp);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("res_stb_hold", res_stb, 1);
      check("res_dat_hold", res_dat, exp);
    end
    en = en_v;
    res_rdy = 1'b1;
    @(posedge clk); #1;
    res_rdy = 1'b0;
    en = 1'($urandom);
    check("res_stb_drop", res_stb, 0);
  endtask

  task automatic send_err(input logic [M-1:0][15:0] e);
    int c = 0;
    while (!err_rdy && c < 50) begin @(posedge clk); #1; c++; end
    if (!err_rdy) timeout("err_rdy");
    err_dat = e;
    err_stb = 1'b1;
    @(posedge clk); #1;
    err_stb = 1'b0;
  endtask

  task automatic recv_fbk(input int stall, input logic [N-1:0][15:0] exp,
                          output logic [N-1:0][15:0] f);
    int c = 0;
    while (!fbk_stb && c < 50) begin @(posedge clk); #1; c++; end
    if (!fbk_stb) timeout("fbk_stb");
    f = fbk_dat;
    check("fbk_dat", fbk_dat, exp);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("fbk_stb_hold", fbk_stb, 1);
      check("fbk_dat_hold", fbk_dat, exp);
    end
    fbk_rdy = 1'b1;
    @(posedge clk); #1;
    fbk_rdy = 1'b0;
    check("fbk_stb_drop", fbk_stb, 0);
    check("arg_rdy_after_fbk", arg_rdy, 1);
  endtask

  task automatic txn(input logic [N-1:0][W-1:0] x, input bit en_v, input bit train,
                     input logic [M-1:0][W-1:0] tgt, input logic [M-1:0][15:0] e_in,
                     input int stall, output logic [M-1:0][W-1:0] r,
                     output logic [N-1:0][15:0] f);
    logic [M-1:0][W-1:0] er;
    logic [M-1:0][15:0]  e;
    logic [N-1:0][15:0]  ef;
    int lat;
    f = '0;
    send_arg(x);
    model_fwd(x);
    for (int j = 0; j < M; j++) er[j] = mres[j][W-1:0];
    recv_res(en_v, stall, er, r, lat);
    check("res_latency", lat, N + 1);
    if (!en_v) begin
      for (int k = 0; k < 3; k++) begin
        check("err_rdy_idle", err_rdy, 0);
        check("arg_rdy_idle", arg_rdy, 1);
        @(posedge clk); #1;
      end
    end else begin
      for (int j = 0; j < M; j++)
        e[j] = train ? 16'(int'(tgt[j]) - int'(mres[j])) : e_in[j];
      send_err(e);
      model_bwd(x, e);
      for (int i = 0; i < N; i++) ef[i] = mfbk[i][15:0];
      recv_fbk(stall, ef, f);
    end
  endtask

  logic [M-1:0][W-1:0] r;
  logic [N-1:0][15:0]  f;
  logic [M-1:0][15:0]  e_r;
  int lat0;

  initial begin
    tbl[0] = '{arg: 16'h0000, tgt: 16'h0000};
    tbl[1] = '{arg: 16'h00ff, tgt: 16'hff00};
    tbl[2] = '{arg: 16'hff00, tgt: 16'hff00};
    tbl[3] = '{arg: 16'hffff, tgt: 16'hffff};

    rst = 1'b1; en = 1'b0;
    arg_stb = 1'b0; res_rdy = 1'b0; err_stb = 1'b0; fbk_rdy = 1'b0;
    arg_dat = '0; err_dat = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_arg_rdy", arg_rdy, 1);
    check("rst_err_rdy", err_rdy, 0);
    check("rst_res_stb", res_stb, 0);
    check("rst_fbk_stb", fbk_stb, 0);
    check("rst_res_dat", res_dat, 0);
    check("rst_fbk_dat", fbk_dat, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // AND on neuron 0, OR on neuron 1, trained together
    for (int ep = 0; ep < 10; ep++)
      for (int v = 0; v < 4; v++) txn(tbl[v].arg, 1'b1, 1'b1, tbl[v].tgt, '0, 0, r, f);
    for (int v = 0; v < 4; v++) begin
      txn(tbl[v].arg, 1'b0, 1'b0, '0, '0, 0, r, f);
      check("and_or_trained", r, tbl[v].tgt);
    end

    // Both outputs held across a 5-cycle consumer stall
    txn(16'hffff, 1'b1, 1'b0, '0, {16'h0010, 16'hfff0}, 5, r, f);

    for (int t = 0; t < 40; t++) begin
      for (int j = 0; j < M; j++)
        e_r[j] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
      txn(16'($urandom), 1'($urandom), 1'b0, '0, e_r, $urandom_range(0, 2), r, f);
    end

    // Saturation of weights and feedback
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    model_reset();
    txn(16'hffff, 1'b1, 1'b0, '0, {16'h7fff, 16'h7fff}, 0, r, f);
    check("sat_fbk_first", f, 32'h0000_0000);
    txn(16'hffff, 1'b1, 1'b0, '0, {16'h7fff, 16'h7fff}, 0, r, f);
    check("sat_fbk_second", f, 32'h7fff_7fff);
    txn(16'hffff, 1'b1, 1'b0, '0, {16'h0001, 16'h0001}, 0, r, f);
    check("sat_weight_probe", f, 32'h00ff_00ff);

    // Reset while the update is in flight
    send_arg(16'h1234);
    model_fwd(16'h1234);
    recv_res(1'b1, 0, {mres[1][W-1:0], mres[0][W-1:0]}, r, lat0);
    send_err({16'h0100, 16'h0100});
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    model_reset();
    check("bwd_rst_arg_rdy", arg_rdy, 1);
    check("bwd_rst_err_rdy", err_rdy, 0);
    check("bwd_rst_fbk_stb", fbk_stb, 0);
    check("bwd_rst_fbk_dat", fbk_dat, 0);
    txn(16'hffff, 1'b1, 1'b0, '0, {16'h0100, 16'h0100}, 0, r, f);
    check("post_rst_res", r, 0);
    check("post_rst_fbk", f, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
